// File: rtl/id_operand_stage_pkg.sv
// Shared opcode/funct constants and FSM state encoding for the decode-stage operand fetch.
// Field positions follow the classic MIPS-I instruction layout.
package id_operand_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/id_use_decode.sv
// Source-register usage decode: reports whether an instruction actually reads rs and/or rt,
// so that hazard detection ignores fields that carry immediates, shift amounts or destinations.
module id_use_decode
    import id_operand_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       use_rs,
    output logic       use_rt
);

    // rs is unused by jumps, LUI and constant shifts; rt only read by R-type, branches, stores
    always_comb begin
        use_rs = 1'b1;
        use_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                use_rt = 1'b1;
                if ((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA)) begin
                    use_rs = 1'b0;
                end else begin
                    use_rs = 1'b1;
                end
            end
            OP_J, OP_JAL, OP_LUI: begin
                use_rs = 1'b0;
            end
            OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: begin
                use_rt = 1'b1;
            end
            default: begin
                use_rs = 1'b1;
                use_rt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-stage operand fetch and ID/EX pipeline register with load-use hazard bubbling
// and a saturating count of inserted load-use bubbles.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    output logic [4:0]       raddr1,
    output logic [4:0]       raddr2,
    input  logic [31:0]      rdata1,
    input  logic [31:0]      rdata2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_load_waddr,
    output logic             stall_req,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_inst,
    output logic [31:0]      ex_src1,
    output logic [31:0]      ex_src2,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    localparam logic [1:0]       BUB_INIT = 2'(LU_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_r, state_s;
    logic [1:0]       bub_r, bub_s;
    logic             use_rs_s, use_rt_s, hazard_s;
    logic             load_s, bubble_s, inc_s;
    logic             ex_valid_r;
    logic [31:0]      ex_pc_r, ex_inst_r, ex_src1_r, ex_src2_r;
    logic [CNT_W-1:0] cnt_r;

    assign raddr1 = if_inst[25:21];
    assign raddr2 = if_inst[20:16];

    id_use_decode u_use_decode (
        .opcode (if_inst[31:26]),
        .funct  (if_inst[5:0]),
        .use_rs (use_rs_s),
        .use_rt (use_rt_s)
    );

    assign hazard_s = if_valid & ex_is_load & (ex_load_waddr != 5'd0) &
                      ((use_rs_s & (raddr1 == ex_load_waddr)) |
                       (use_rt_s & (raddr2 == ex_load_waddr)));

    assign stall_req = ex_stall | (hazard_s & (state_r == ST_RUN)) | (state_r == ST_STALL);

    // Next-state and ID/EX control; the last STALL cycle captures operands instead of bubbling
    always_comb begin
        state_s  = state_r;
        bub_s    = bub_r;
        load_s   = 1'b0;
        bubble_s = 1'b0;
        inc_s    = 1'b0;
        if (flush) begin
            state_s  = ST_RUN;
            bubble_s = 1'b1;
        end else if (ex_stall) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_s) begin
                        state_s  = ST_STALL;
                        bub_s    = BUB_INIT;
                        bubble_s = 1'b1;
                        inc_s    = 1'b1;
                    end else begin
                        load_s = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (bub_r == 2'd0) begin
                        state_s = ST_RUN;
                        load_s  = 1'b1;
                    end else begin
                        bub_s    = bub_r - 2'd1;
                        bubble_s = 1'b1;
                        inc_s    = 1'b1;
                    end
                end
                default: begin
                    state_s  = ST_RUN;
                    bubble_s = 1'b1;
                end
            endcase
        end
    end

    // FSM, ID/EX register and saturating bubble counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_RUN;
            bub_r      <= 2'd0;
            ex_valid_r <= 1'b0;
            ex_pc_r    <= 32'd0;
            ex_inst_r  <= 32'd0;
            ex_src1_r  <= 32'd0;
            ex_src2_r  <= 32'd0;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            bub_r   <= bub_s;
            if (bubble_s) begin
                ex_valid_r <= 1'b0;
            end else if (load_s) begin
                ex_valid_r <= if_valid;
                ex_pc_r    <= if_pc;
                ex_inst_r  <= if_inst;
                ex_src1_r  <= rdata1;
                ex_src2_r  <= rdata2;
            end else begin
                ex_valid_r <= ex_valid_r;
            end
            if (inc_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign ex_valid     = ex_valid_r;
    assign ex_pc        = ex_pc_r;
    assign ex_inst      = ex_inst_r;
    assign ex_src1      = ex_src1_r;
    assign ex_src2      = ex_src2_r;
    assign lu_stall_cnt = cnt_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench: instance a uses LU_STALL_CYCLES=1/CNT_W=32, instance b uses
// LU_STALL_CYCLES=2/CNT_W=4; both share stimulus and are reset together between phases.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        resetn, flush, ex_stall, if_valid, ex_is_load;
    logic [31:0] if_pc, if_inst, rdata1, rdata2;
    logic [4:0]  ex_load_waddr;

    logic [4:0]  a_raddr1, a_raddr2, b_raddr1, b_raddr2;
    logic        a_stall_req, a_ex_valid, b_stall_req, b_ex_valid;
    logic [31:0] a_ex_pc, a_ex_inst, a_ex_src1, a_ex_src2;
    logic [31:0] b_ex_pc, b_ex_inst, b_ex_src1, b_ex_src2;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] I_ADDU_3_1_2 = 32'h0022_1821;
    localparam logic [31:0] I_ADDU_5_4_0 = 32'h0080_2821;
    localparam logic [31:0] I_ADDU_5_0_0 = 32'h0000_2821;
    localparam logic [31:0] I_LUI_4      = 32'h3C04_1234;
    localparam logic [31:0] I_SLL_RS4    = 32'h0087_3080; // shift with rs field = 4, rt = 7
    localparam logic [31:0] I_J_RS4      = 32'h0880_0000; // jump target bits overlap rs = 4
    localparam logic [31:0] I_ADDIU_4_9  = 32'h2524_0001; // rt = 4 is a destination here
    localparam logic [31:0] I_SW_4_9     = 32'hAD24_0000;

    always #5 clk = ~clk;

    id_operand_stage #(.LU_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_stall(ex_stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .raddr1(a_raddr1), .raddr2(a_raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .ex_is_load(ex_is_load), .ex_load_waddr(ex_load_waddr),
        .stall_req(a_stall_req), .ex_valid(a_ex_valid), .ex_pc(a_ex_pc),
        .ex_inst(a_ex_inst), .ex_src1(a_ex_src1), .ex_src2(a_ex_src2),
        .lu_stall_cnt(a_cnt)
    );

    id_operand_stage #(.LU_STALL_CYCLES(2), .CNT_W(4)) dut_b (
        .clk(clk), .resetn(resetn), .flush(flush), .ex_stall(ex_stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .raddr1(b_raddr1), .raddr2(b_raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .ex_is_load(ex_is_load), .ex_load_waddr(ex_load_waddr),
        .stall_req(b_stall_req), .ex_valid(b_ex_valid), .ex_pc(b_ex_pc),
        .ex_inst(b_ex_inst), .ex_src1(b_ex_src1), .ex_src2(b_ex_src2),
        .lu_stall_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; ex_stall = 1'b0; if_valid = 1'b1;
        if_pc = 32'h0; if_inst = 32'h0; rdata1 = 32'h0; rdata2 = 32'h0;
        ex_is_load = 1'b0; ex_load_waddr = 5'd0;
        #1;
        chk("reset_a_valid", {31'd0, a_ex_valid}, 32'd0);
        chk("reset_a_pc",    a_ex_pc, 32'd0);
        chk("reset_a_src1",  a_ex_src1, 32'd0);
        chk("reset_a_cnt",   a_cnt, 32'd0);
        chk("reset_b_cnt",   {28'd0, b_cnt}, 32'd0);
        step();
        resetn = 1'b1;
        step();

        // Normal advance
        if_pc = 32'h0000_0100; if_inst = I_ADDU_3_1_2; rdata1 = 32'd5; rdata2 = 32'd7;
        #1;
        chk("raddr1", {27'd0, a_raddr1}, 32'd1);
        chk("raddr2", {27'd0, a_raddr2}, 32'd2);
        chk("b_raddr1", {27'd0, b_raddr1}, 32'd1);
        chk("adv_no_stall", {31'd0, a_stall_req}, 32'd0);
        step();
        chk("adv_valid", {31'd0, a_ex_valid}, 32'd1);
        chk("adv_src1",  a_ex_src1, 32'd5);
        chk("adv_src2",  a_ex_src2, 32'd7);
        chk("adv_pc",    a_ex_pc, 32'h0000_0100);
        chk("adv_inst",  a_ex_inst, I_ADDU_3_1_2);

        // Load-use, one bubble
        ex_is_load = 1'b1; ex_load_waddr = 5'd4;
        if_pc = 32'h0000_0104; if_inst = I_ADDU_5_4_0; rdata1 = 32'h11; rdata2 = 32'h22;
        #1;
        chk("lu_stall_req", {31'd0, a_stall_req}, 32'd1);
        step();
        chk("lu_bubble", {31'd0, a_ex_valid}, 32'd0);
        chk("lu_cnt1",   a_cnt, 32'd1);
        ex_is_load = 1'b0;
        #1;
        chk("lu_stall_in_stall", {31'd0, a_stall_req}, 32'd1);
        step();
        chk("lu_enter_valid", {31'd0, a_ex_valid}, 32'd1);
        chk("lu_enter_inst",  a_ex_inst, I_ADDU_5_4_0);
        chk("lu_enter_src1",  a_ex_src1, 32'h11);
        chk("lu_cnt_after",   a_cnt, 32'd1);
        chk("lu_back_run",    {31'd0, a_stall_req}, 32'd0);

        // No false hazards against load to $4, nor any hazard against $0
        ex_is_load = 1'b1; ex_load_waddr = 5'd4;
        if_inst = I_LUI_4; #1;
        chk("nf_lui", {31'd0, a_stall_req}, 32'd0);
        step();
        chk("nf_lui_inst", a_ex_inst, I_LUI_4);
        if_inst = I_SLL_RS4; #1;
        chk("nf_sll", {31'd0, a_stall_req}, 32'd0);
        step();
        chk("nf_sll_valid", {31'd0, a_ex_valid}, 32'd1);
        if_inst = I_J_RS4; #1;
        chk("nf_j", {31'd0, a_stall_req}, 32'd0);
        if_inst = I_ADDIU_4_9; #1;
        chk("nf_addiu", {31'd0, a_stall_req}, 32'd0);
        step();
        if_inst = I_ADDU_5_4_0; if_valid = 1'b0; #1;
        chk("nf_invalid", {31'd0, a_stall_req}, 32'd0);
        step();
        chk("nf_invalid_ex", {31'd0, a_ex_valid}, 32'd0);
        if_valid = 1'b1; ex_load_waddr = 5'd0; if_inst = I_ADDU_5_0_0; #1;
        chk("nf_zero_dest", {31'd0, a_stall_req}, 32'd0);
        step();
        ex_load_waddr = 5'd4; if_inst = I_SW_4_9; #1;
        chk("sw_rt_hazard", {31'd0, a_stall_req}, 32'd1);
        step();
        ex_is_load = 1'b0;
        step();
        chk("sw_cnt", a_cnt, 32'd2);

        // Asynchronous reset mid-run
        resetn = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, a_ex_valid}, 32'd0);
        chk("midreset_cnt",   a_cnt, 32'd0);
        chk("midreset_run",   {31'd0, a_stall_req}, 32'd0);
        resetn = 1'b1;
        step();

        // Two bubbles per hazard on instance b
        if_pc = 32'h0000_0200; if_inst = I_ADDU_5_4_0; rdata1 = 32'h33; rdata2 = 32'h44;
        ex_is_load = 1'b1; ex_load_waddr = 5'd4; #1;
        chk("b_stall_req", {31'd0, b_stall_req}, 32'd1);
        step();
        chk("b_bub1_valid", {31'd0, b_ex_valid}, 32'd0);
        chk("b_bub1_cnt",   {28'd0, b_cnt}, 32'd1);
        ex_is_load = 1'b0;
        step();
        chk("b_bub2_valid", {31'd0, b_ex_valid}, 32'd0);
        chk("b_bub2_cnt",   {28'd0, b_cnt}, 32'd2);
        chk("b_bub2_req",   {31'd0, b_stall_req}, 32'd1);
        step();
        chk("b_enter_valid", {31'd0, b_ex_valid}, 32'd1);
        chk("b_enter_pc",    b_ex_pc, 32'h0000_0200);
        chk("b_enter_inst",  b_ex_inst, I_ADDU_5_4_0);
        chk("b_enter_src",   b_ex_src1 ^ b_ex_src2, 32'h33 ^ 32'h44);
        chk("b_enter_cnt",   {28'd0, b_cnt}, 32'd2);

        // ex_stall during STALL freezes FSM and counter
        ex_is_load = 1'b1;
        step();
        chk("b_frz_start", {28'd0, b_cnt}, 32'd3);
        ex_is_load = 1'b0; ex_stall = 1'b1;
        step();
        step();
        chk("b_frz_cnt",   {28'd0, b_cnt}, 32'd3);
        chk("b_frz_valid", {31'd0, b_ex_valid}, 32'd0);
        chk("b_frz_req",   {31'd0, b_stall_req}, 32'd1);
        ex_stall = 1'b0;
        step();
        chk("b_frz_resume_cnt", {28'd0, b_cnt}, 32'd4);
        chk("b_frz_resume_val", {31'd0, b_ex_valid}, 32'd0);
        step();
        chk("b_frz_exit_val", {31'd0, b_ex_valid}, 32'd1);

        // Flush during STALL
        ex_is_load = 1'b1;
        step();
        chk("b_fl_cnt5", {28'd0, b_cnt}, 32'd5);
        ex_is_load = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; #1;
        chk("b_fl_valid", {31'd0, b_ex_valid}, 32'd0);
        chk("b_fl_cnt",   {28'd0, b_cnt}, 32'd5);
        chk("b_fl_run",   {31'd0, b_stall_req}, 32'd0);
        step();
        chk("b_fl_adv", {31'd0, b_ex_valid}, 32'd1);

        // Saturation of the 4-bit counter: 5 + 2*5 = 15, then it must hold
        for (int i = 0; i < 5; i++) begin
            ex_is_load = 1'b1;
            step();
            ex_is_load = 1'b0;
            step();
            step();
        end
        chk("b_sat_reach", {28'd0, b_cnt}, 32'd15);
        ex_is_load = 1'b1;
        step();
        ex_is_load = 1'b0;
        step();
        step();
        chk("b_sat_hold", {28'd0, b_cnt}, 32'd15);
        chk("b_sat_valid", {31'd0, b_ex_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
